multi_channel_timer: RTL
========================

MULTI_CHANNEL_TIMER -- requirements
Module: multi_channel_timer

Interface
REQ-001 Parameter NCH, default 4: number of independent timer channels, range 1..16.
REQ-002 Parameter CLK_HZ, default 100000000: clk frequency; one slow tick is 1 s.
REQ-003 Parameter FAST_DIV, default 100: fast mode runs FAST_DIV times faster than slow mode; CLK_HZ SHALL be divisible by FAST_DIV.
REQ-004 clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 ch_sel  in  max(1,clog2(NCH))  target channel for commands.
REQ-007 cmd_start, cmd_pause, cmd_load, cmd_clear  in  1 each  single-cycle command strobes.
REQ-008 set_min, set_sec  in  6 each  load value in binary.
REQ-009 set_up, set_fast  in  1 each  direction (1=count up) and speed (1=fast), captured on load.
REQ-010 disp_sel  in  max(1,clog2(NCH))  channel shown on the digit outputs.
REQ-011 min1, min2, sec1, sec2  out  4 each  BCD tens/units of the displayed channel's minutes and seconds.
REQ-012 running  out  NCH  bit i is high while channel i is in RUN.
REQ-013 time_up  out  NCH  sticky completion flag per channel.
REQ-014 any_up  out  1  OR of time_up.

Function
REQ-015 A shared prescaler SHALL emit tick_fast every CLK_HZ/FAST_DIV cycles, and tick_slow on every FAST_DIV-th tick_fast, coincident with that tick_fast.
REQ-016 Each channel SHALL hold min[5:0], sec[5:0], dir, fast and a state, one of IDLE, RUN, PAUSE or DONE.
REQ-017 A channel SHALL advance only in RUN, on its selected tick (tick_fast if fast=1, else tick_slow), by one second.
REQ-018 Down count: sec decrements; at sec=0 with min>0, sec becomes 59 and min decrements.
REQ-019 Down count, transition to 00:00: state SHALL go to DONE and time_up SHALL be set in the same clock edge.
REQ-020 Up count: sec increments; at sec=59, sec becomes 0 and min increments.
REQ-021 Up count, transition to 59:59: state SHALL go to DONE and time_up SHALL be set in the same clock edge.
REQ-022 cmd_load applies in any state and does the following:
- loads set_min and set_sec, each clamped to 59 if greater;
- captures set_up and set_fast;
- sets state to IDLE and clears time_up.
REQ-023 cmd_start: IDLE->RUN and PAUSE->RUN. It is ignored in RUN and DONE.
REQ-024 cmd_start is also ignored if the channel is down-counting from 00:00, or up-counting from 59:59.
REQ-025 cmd_pause: RUN->PAUSE. It is ignored in every other state.
REQ-026 cmd_clear applies in any state and does the following:
- sets the value to 00:00;
- sets state to IDLE and clears time_up;
- leaves dir and fast unchanged.
REQ-027 When several commands are asserted in the same cycle, priority SHALL be clear > load > pause > start.
REQ-028 Commands SHALL affect only the channel addressed by ch_sel; all other channels continue unaffected.
REQ-029 If a command and a tick reach the same channel in the same cycle, the command SHALL win and the tick is dropped for that channel.
REQ-030 Commands take effect at the next clock edge, with one-cycle latency to running and time_up.
REQ-031 min1, min2, sec1 and sec2 SHALL be combinational from disp_sel and the registered channel value.
REQ-032 Digit conversion: min1=min/10 and min2=min%10, giving values 0..5 and 0..9; seconds convert the same way.
REQ-033 An out-of-range disp_sel (value >= NCH) SHALL display 0,0,0,0.
REQ-034 DONE SHALL persist, with time_up held high, until cmd_load or cmd_clear on that channel.

Reset
REQ-035 On reset_n low, all of the following SHALL clear asynchronously:
- every channel to IDLE, 00:00, dir=0, fast=0;
- time_up, running, any_up and the prescaler to 0.
REQ-036 The first tick after reset_n deasserts SHALL occur a full prescaler period after release.

Verification (bench uses CLK_HZ=1000, FAST_DIV=10)
REQ-037 Down count, slow: load ch0 00:02 down slow, start.
- running[0]=1.
- After 2000 cycles: 00:00, state DONE, time_up[0]=1, any_up=1, running[0]=0.
REQ-038 Up count, fast: load ch1 59:58 up fast, start.
- After 200 cycles: 59:59 displayed (disp_sel=1 gives 5,9,5,9) and time_up[1]=1.
REQ-039 Pause and resume: load ch2 01:00 down slow, start, wait 1000 cycles, pause.
- Value holds at 00:59 for 5000 cycles.
- Start: value resumes decrementing.
REQ-040 Command priority: load and clear together on ch3 -> 00:00, IDLE. Load value 00:00 down, then start -> remains IDLE, running[3]=0.
REQ-041 Clamping and isolation: load ch0 with set_min=63, set_sec=60 -> reads 59:59. Concurrently, ch1 is running and its count is unaffected.
REQ-042 Reset mid-run: assert reset_n low during RUN -> all outputs 0 immediately without a clock edge. After release, no channel advances.

Source files
------------

// File: rtl/multi_channel_timer.sv
// Multi-channel minute/second timer.
// One shared prescaler produces a fast tick and a slow (1 s) tick. Each channel
// has its own IDLE/RUN/PAUSE/DONE state machine and counts up or down in
// mm:ss. The channel picked by disp_sel is shown as four BCD digits.
module multi_channel_timer #(
    parameter int NCH      = 4,
    parameter int CLK_HZ   = 100000000,
    parameter int FAST_DIV = 100,
    localparam int SELW    = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [SELW-1:0] ch_sel,
    input  logic            cmd_start,
    input  logic            cmd_pause,
    input  logic            cmd_load,
    input  logic            cmd_clear,
    input  logic [5:0]      set_min,
    input  logic [5:0]      set_sec,
    input  logic            set_up,
    input  logic            set_fast,
    input  logic [SELW-1:0] disp_sel,
    output logic [3:0]      min1,
    output logic [3:0]      min2,
    output logic [3:0]      sec1,
    output logic [3:0]      sec2,
    output logic [NCH-1:0]  running,
    output logic [NCH-1:0]  time_up,
    output logic            any_up
);

    localparam int PDIV = CLK_HZ / FAST_DIV;
    localparam int PW   = (PDIV > 1) ? $clog2(PDIV) : 1;
    localparam int FW   = (FAST_DIV > 1) ? $clog2(FAST_DIV) : 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    logic [PW-1:0] pre_q, pre_d;
    logic [FW-1:0] fdiv_q, fdiv_d;
    logic          tick_fast, tick_slow;

    // Ticks are decoded from the counters at their terminal count, so the
    // first tick after reset lands a full period after release.
    assign tick_fast = (pre_q == PW'(PDIV - 1));
    assign tick_slow = tick_fast && (fdiv_q == FW'(FAST_DIV - 1));

    // Prescaler next-state: wrap the cycle counter, count fast ticks.
    always_comb begin
        pre_d  = tick_fast ? '0 : pre_q + PW'(1);
        fdiv_d = fdiv_q;
        if (tick_fast) begin
            fdiv_d = tick_slow ? '0 : fdiv_q + FW'(1);
        end
    end

    // Prescaler registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pre_q  <= '0;
            fdiv_q <= '0;
        end else begin
            pre_q  <= pre_d;
            fdiv_q <= fdiv_d;
        end
    end

    logic [6*NCH-1:0] min_all, sec_all;
    logic [NCH-1:0]   run_all, tu_all;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
        logic [5:0] min_q, min_d, sec_q, sec_d;
        logic       dir_q, dir_d, fast_q, fast_d, tu_q, tu_d;
        state_e     st_q, st_d;
        logic       hit, tick, at_end;
        logic [5:0] nmin, nsec;

        // Channel next-state: any command addressed here wins over a tick.
        always_comb begin
            hit    = (ch_sel == SELW'(gi)) &&
                     (cmd_start || cmd_pause || cmd_load || cmd_clear);
            tick   = fast_q ? tick_fast : tick_slow;
            at_end = dir_q ? (min_q == 6'd59 && sec_q == 6'd59)
                           : (min_q == 6'd0  && sec_q == 6'd0);
            nmin   = min_q;
            nsec   = sec_q;
            if (dir_q) begin
                if (sec_q == 6'd59) begin
                    nsec = 6'd0;
                    nmin = min_q + 6'd1;
                end else begin
                    nsec = sec_q + 6'd1;
                end
            end else begin
                if (sec_q != 6'd0) begin
                    nsec = sec_q - 6'd1;
                end else if (min_q != 6'd0) begin
                    nsec = 6'd59;
                    nmin = min_q - 6'd1;
                end
            end
            min_d  = min_q;
            sec_d  = sec_q;
            dir_d  = dir_q;
            fast_d = fast_q;
            tu_d   = tu_q;
            st_d   = st_q;
            if (hit) begin
                if (cmd_clear) begin
                    min_d = 6'd0;
                    sec_d = 6'd0;
                    st_d  = ST_IDLE;
                    tu_d  = 1'b0;
                end else if (cmd_load) begin
                    min_d  = (set_min > 6'd59) ? 6'd59 : set_min;
                    sec_d  = (set_sec > 6'd59) ? 6'd59 : set_sec;
                    dir_d  = set_up;
                    fast_d = set_fast;
                    st_d   = ST_IDLE;
                    tu_d   = 1'b0;
                end else if (cmd_pause) begin
                    if (st_q == ST_RUN) st_d = ST_PAUSE;
                end else if ((st_q == ST_IDLE || st_q == ST_PAUSE) && !at_end) begin
                    st_d = ST_RUN;
                end
            end else if (st_q == ST_RUN && tick) begin
                min_d = nmin;
                sec_d = nsec;
                if (dir_q ? (nmin == 6'd59 && nsec == 6'd59)
                          : (nmin == 6'd0  && nsec == 6'd0)) begin
                    st_d = ST_DONE;
                    tu_d = 1'b1;
                end
            end
        end

        // Channel registers.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                min_q  <= '0;
                sec_q  <= '0;
                dir_q  <= 1'b0;
                fast_q <= 1'b0;
                tu_q   <= 1'b0;
                st_q   <= ST_IDLE;
            end else begin
                min_q  <= min_d;
                sec_q  <= sec_d;
                dir_q  <= dir_d;
                fast_q <= fast_d;
                tu_q   <= tu_d;
                st_q   <= st_d;
            end
        end

        assign min_all[gi*6 +: 6] = min_q;
        assign sec_all[gi*6 +: 6] = sec_q;
        assign run_all[gi]        = (st_q == ST_RUN);
        assign tu_all[gi]         = tu_q;
    end

    // Split a 0..59 value into tens and units digits.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [5:0] base;
        if (v >= 6'd50) begin
            tens = 4'd5; base = 6'd50;
        end else if (v >= 6'd40) begin
            tens = 4'd4; base = 6'd40;
        end else if (v >= 6'd30) begin
            tens = 4'd3; base = 6'd30;
        end else if (v >= 6'd20) begin
            tens = 4'd2; base = 6'd20;
        end else if (v >= 6'd10) begin
            tens = 4'd1; base = 6'd10;
        end else begin
            tens = 4'd0; base = 6'd0;
        end
        return {tens, 4'(v - base)};
    endfunction

    logic [5:0] disp_min, disp_sec;

    // Display mux; a disp_sel beyond the last channel matches nothing and shows zeros.
    always_comb begin
        disp_min = '0;
        disp_sec = '0;
        for (int i = 0; i < NCH; i++) begin
            if (disp_sel == SELW'(i)) begin
                disp_min = min_all[i*6 +: 6];
                disp_sec = sec_all[i*6 +: 6];
            end
        end
    end

    assign {min1, min2} = to_bcd(disp_min);
    assign {sec1, sec2} = to_bcd(disp_sec);
    assign running      = run_all;
    assign time_up      = tu_all;
    assign any_up       = |tu_all;

endmodule
